// File: rtl/bitmap_index_encoder.sv
// bitmap_index_encoder: drains a multi-hot select bitmap as a stream of binary indices.
// Define BITMAP_INDEX_ENCODER_MSB_FIRST_EN to emit the highest set bit first instead of the lowest.
`default_nettype none

module bitmap_index_encoder #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_pulse,
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [WIDTH-1:0] w_sel_onehot;
    logic             r_zero_pulse;
    logic             w_zero_pulse_nxt;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;

    // Later loop iterations overwrite earlier ones, so the scan direction picks the winning end.
    always_comb begin
        w_idx = '0;
`ifdef BITMAP_INDEX_ENCODER_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (r_pending[i]) w_idx = IDX_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) w_idx = IDX_W'(i);
        end
`endif
    end

    always_comb begin
        w_last       = (r_pending != '0) && ((r_pending & (r_pending - WIDTH'(1))) == '0);
        w_sel_onehot = WIDTH'(1) << w_idx;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pending_nxt    = r_pending;
        w_zero_pulse_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        w_pending_nxt = in_vec;
                        w_state_nxt   = S_RUN;
                    end else begin
                        w_zero_pulse_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~w_sel_onehot;
                    if (w_last) begin
                        w_pending_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_zero_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_zero_pulse <= w_zero_pulse_nxt;
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN);
    assign out_idx    = w_idx;
    assign out_last   = w_last;
    assign zero_pulse = r_zero_pulse;

endmodule

`default_nettype wire

// File: tb/tb_bitmap_index_encoder.sv
// tb_bitmap_index_encoder: directed and randomized bitmaps checked against a set-bit list model.
`default_nettype none

module tb_bitmap_index_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        zero_pulse;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    bitmap_index_encoder #(.WIDTH(32), .IDX_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_pulse(zero_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_out_idx"},    32'(out_idx),    32'd0);
        chk({tag, "_out_last"},   32'(out_last),   32'd0);
        chk({tag, "_zero_pulse"}, 32'(zero_pulse), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    // Reference: the list of selected register numbers in emission order.
    task automatic build_model(input logic [31:0] v);
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
`ifdef BITMAP_INDEX_ENCODER_MSB_FIRST_EN
                exp_q.push_front(i);
`else
                exp_q.push_back(i);
`endif
            end
        end
    endtask

    // Enters and leaves at a falling edge with the DUT idle (unless max_out truncates the drain).
    task automatic send(input logic [31:0] v, input int stall_first, input bit rnd_ready,
                        input int max_out);
        int k;
        int cyc;
        build_model(v);
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = $urandom;
        if (exp_q.size() == 0) begin
            chk("zero_pulse_hi",     32'(zero_pulse), 32'd1);
            chk("zero_no_valid",     32'(out_valid),  32'd0);
            chk("zero_in_ready",     32'(in_ready),   32'd1);
            @(negedge clk);
            chk("zero_pulse_lo",     32'(zero_pulse), 32'd0);
            return;
        end
        k   = 0;
        cyc = 0;
        while (k < exp_q.size() && k < max_out) begin
            chk("run_out_valid", 32'(out_valid), 32'd1);
            chk("run_busy",      32'(busy),      32'd1);
            chk("run_in_ready",  32'(in_ready),  32'd0);
            chk("run_out_idx",   32'(out_idx),   32'(exp_q[k]));
            chk("run_out_last",  32'(out_last),  32'(k == exp_q.size() - 1));
            if (cyc < stall_first)  out_ready = 1'b0;
            else if (rnd_ready)     out_ready = 1'($urandom_range(0, 1));
            else                    out_ready = 1'b1;
            @(negedge clk);
            cyc++;
            if (out_ready) k++;
        end
        out_ready = 1'b0;
        if (k == exp_q.size()) begin
            chk("done_out_valid", 32'(out_valid), 32'd0);
            chk("done_busy",      32'(busy),      32'd0);
            chk("done_in_ready",  32'(in_ready),  32'd1);
            chk("done_out_last",  32'(out_last),  32'd0);
        end
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        send(32'h0000_0001, 0, 1'b0, 32);
        send(32'h8000_0105, 0, 1'b0, 32);
        send(32'h0000_0030, 3, 1'b0, 32);

        // Zero bitmaps accepted on consecutive cycles.
        in_valid = 1'b1;
        in_vec   = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zb2b_pulse",    32'(zero_pulse), 32'd1);
            chk("zb2b_in_ready", 32'(in_ready),   32'd1);
            chk("zb2b_no_valid", 32'(out_valid),  32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("zb2b_pulse_end", 32'(zero_pulse), 32'd0);
        send(32'h0000_0000, 0, 1'b0, 32);

        // Reset mid-drain, with a competing handshake on the reset edge.
        send(32'hFFFF_FFFF, 0, 1'b0, 3);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 32'h0000_0F00;
        out_ready = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_after_valid", 32'(out_valid), 32'd0);
        chk("midrst_after_busy",  32'(busy),      32'd0);
        out_ready = 1'b0;

        // Reset wins over an acceptance while idle.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_vec   = 32'h0000_0002;
        @(negedge clk);
        chk_reset_outputs("idlerst");
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = 32'd1 << $urandom_range(0, 31);
                2:       v = $urandom & $urandom & $urandom;
                default: v = $urandom;
            endcase
            send(v, int'($urandom_range(0, 2)), 1'b1, 32);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bitmap_index_encoder.md
# bitmap_index_encoder

Converts a 32-bit multi-hot select bitmap back into a serial stream of 5-bit binary register indices, one per accepted output handshake. It is the inverse companion of the register file's 5-to-32 write-select decoder: control logic hands it a set of register-select lines, such as a dirty or writeback mask, and it emits each selected register number in turn. It sits between the bitmap producer and any consumer that addresses the register file by binary index.

## Interface
Parameters:
- WIDTH, 32, bitmap width; must equal 2**IDX_W.
- IDX_W, 5, index width.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept a bitmap.
- in_vec  input  WIDTH  select bitmap; bit i set means register i is selected.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer takes out_idx.
- out_idx  output  IDX_W  binary index of the current selected bit.
- out_last  output  1  current index is the final one of this bitmap.
- zero_pulse  output  1  one-cycle flag: an all-zero bitmap was accepted and dropped.
- busy  output  1  high in RUN state.

## Operation
- Registers: state (IDLE/RUN), pending[WIDTH-1:0], zero_pulse.
- IDLE: in_ready=1, out_valid=0.
  - If in_valid and in_vec!=0, then pending<=in_vec and the block moves to RUN.
  - If in_valid and in_vec==0, the bitmap is consumed and dropped: zero_pulse<=1 for the next cycle and the block stays in IDLE.
- RUN: in_ready=0, out_valid=1.
  - out_idx is the lowest set bit of pending, encoded combinationally from the register.
  - out_last=1 when pending has exactly one bit set.
- In RUN, when out_valid and out_ready, the bit at out_idx is cleared in pending.
  - If out_last, state<=IDLE and pending becomes 0.
- out_idx, out_last and out_valid must remain stable while out_valid=1 and out_ready=0.
- in_ready is low throughout RUN, so a new bitmap is never accepted while the current one is draining.
- busy is high exactly when state==RUN.
- No arithmetic wraps; every index is in the range 0..WIDTH-1.

## Timing
- Reset values: state=IDLE, pending=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, zero_pulse=0, busy=0.
- Latency: if a nonzero bitmap is accepted on edge N, out_valid is high after edge N and the first index is presented in the cycle that follows.
- Throughput: one index per cycle while out_ready is held high. A bitmap with k set bits occupies RUN for exactly k cycles.
- Back-to-back bitmaps: in_ready rises in the cycle after the last output handshake, so there is one idle cycle between bitmaps.
- Zero bitmap: zero_pulse is high in the single cycle after acceptance. in_ready stays high, so bitmaps can be accepted every cycle.
- Reset mid-operation: rst on any edge forces the reset values on that edge. Pending indices are discarded and no out_valid appears in the following cycle.
- rst has priority over all handshakes on the same edge.
- All outputs are driven from registers or from pure decode of registers. There are no combinational paths from input to output, except that in_ready depends only on state.

## Configuration
- Macro: BITMAP_INDEX_ENCODER_MSB_FIRST_EN.
- Not defined (default): indices are emitted in ascending order, lowest set bit first.
- Defined: indices are emitted in descending order, highest set bit first. out_last then means exactly one bit remains, as in the default.
- Only the emission order changes. Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset then single bit: hold rst 2 cycles, then in_vec=32'h0000_0001 with in_valid=1 and out_ready=1. Required: one output, out_idx=0, out_last=1, then IDLE with in_ready=1.
- Multi-bit, default order: in_vec=32'h8000_0105 with out_ready=1. Required: out_idx 0,2,8,31 on consecutive cycles, out_last only on 31, busy high for 4 cycles.
- Backpressure: in_vec=32'h0000_0030, with out_ready=0 for 3 cycles and then 1. Required: out_idx=4 held stable for 3 cycles, then 4 and 5 are emitted, with out_last on 5.
- Zero bitmap: in_vec=0 accepted. Required: zero_pulse=1 for exactly one cycle, out_valid never rises, in_ready stays 1.
- Reset mid-drain: in_vec=32'hFFFF_FFFF, then assert rst after 3 outputs. Required: every output is at its reset value on the following cycle, and no further indices appear.
- MSB-first build: with BITMAP_INDEX_ENCODER_MSB_FIRST_EN defined, in_vec=32'h8000_0105. Required: out_idx 31,8,2,0, with out_last on 0.
